// File: rtl/mux16_rr_arbiter.sv
// mux16_rr_arbiter
// Round-robin arbiter that owns the select input of a 16:1 single-bit mux.
// One requester at a time is granted; its index drives sel until it raises
// done or withdraws its request. A mandatory idle cycle separates owners.
//
// Ports:
//   clk      - clock, rising edge
//   reset    - synchronous active-high reset
//   req      - request vector, bit k belongs to requester k
//   done     - current owner has finished (only looked at while granting)
//   sel      - index of the current or most recent grantee (to muxer16.sel)
//   grant    - one-hot grant vector, zero when no grant is active
//   valid    - high while a grant is active (equals |grant)
//   timeout  - one-cycle pulse when a grant is forcibly revoked
//
// Optional feature: define MUX16_ARB_TIMEOUT_EN to build the hold counter that
// revokes a grant after HOLD_MAX cycles. Without it timeout is tied to 0 and
// HOLD_MAX is unused.
module mux16_rr_arbiter #(
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] req,
    input  logic        done,
    output logic [3:0]  sel,
    output logic [15:0] grant,
    output logic        valid,
    output logic        timeout
);

    if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_hold_max_check
        $error("HOLD_MAX must be in 2..255");
    end

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StGrant = 2'd1
    } state_t;

    state_t     state;
    logic [3:0] ptr;
    logic [3:0] pick;
    logic       any_req;
    logic       release_now;

    // First set request at or after ptr, wrapping mod 16. Scanning from the
    // farthest offset down lets the nearest one win.
    always_comb begin
        logic [3:0] idx;
        pick    = ptr;
        any_req = |req;
        for (int i = 15; i >= 0; i--) begin
            idx = ptr + 4'(i);
            if (req[idx]) begin
                pick = idx;
            end
        end
    end

    assign release_now = done | ~req[sel];

`ifdef MUX16_ARB_TIMEOUT_EN
    localparam logic [7:0] HoldLast = 8'(HOLD_MAX - 1);

    logic [7:0] hold_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= StIdle;
            ptr      <= 4'd0;
            sel      <= 4'd0;
            grant    <= 16'd0;
            valid    <= 1'b0;
            timeout  <= 1'b0;
            hold_cnt <= 8'd0;
        end else begin
            timeout <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (any_req) begin
                        sel      <= pick;
                        grant    <= 16'(1) << pick;
                        valid    <= 1'b1;
                        ptr      <= pick + 4'd1;
                        hold_cnt <= 8'd0;
                        state    <= StGrant;
                    end
                end
                StGrant: begin
                    // A normal release wins over a coincident limit hit.
                    if (release_now) begin
                        grant <= 16'd0;
                        valid <= 1'b0;
                        state <= StIdle;
                    end else if (hold_cnt == HoldLast) begin
                        grant   <= 16'd0;
                        valid   <= 1'b0;
                        timeout <= 1'b1;
                        state   <= StIdle;
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end
`else
    assign timeout = 1'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= StIdle;
            ptr   <= 4'd0;
            sel   <= 4'd0;
            grant <= 16'd0;
            valid <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (any_req) begin
                        sel   <= pick;
                        grant <= 16'(1) << pick;
                        valid <= 1'b1;
                        ptr   <= pick + 4'd1;
                        state <= StGrant;
                    end
                end
                StGrant: begin
                    if (release_now) begin
                        grant <= 16'd0;
                        valid <= 1'b0;
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Scoreboard bench for mux16_rr_arbiter: the stimulus process pushes the
// reference model's expected outputs for each edge, a monitor pops and
// compares them once the DUT has updated.
module tb_mux16_rr_arbiter;

    localparam int HOLD = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] req;
    logic        done;
    logic [3:0]  sel;
    logic [15:0] grant;
    logic        valid;
    logic        timeout;

    mux16_rr_arbiter #(.HOLD_MAX(HOLD)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .done    (done),
        .sel     (sel),
        .grant   (grant),
        .valid   (valid),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  sel;
        logic [15:0] grant;
        logic        valid;
        logic        timeout;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: owner is -1 when nobody holds the mux.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_sel   = 0;
    int m_held  = 0;
    bit m_to    = 0;

    task automatic model_edge();
        exp_t e;
        if (reset) begin
            m_owner = -1; m_ptr = 0; m_sel = 0; m_held = 0; m_to = 0;
        end else begin
            m_to = 0;
            if (m_owner < 0) begin
                for (int k = 0; k < 16; k++) begin
                    int idx;
                    idx = (m_ptr + k) % 16;
                    if (req[idx] && m_owner < 0) m_owner = idx;
                end
                if (m_owner >= 0) begin
                    m_sel  = m_owner;
                    m_ptr  = (m_owner + 1) % 16;
                    m_held = 1;
                end
            end else if (done || !req[m_owner]) begin
                m_owner = -1;
            end else begin
`ifdef MUX16_ARB_TIMEOUT_EN
                if (m_held >= HOLD) begin
                    m_owner = -1;
                    m_to    = 1;
                end else begin
                    m_held++;
                end
`endif
            end
        end
        e.sel     = 4'(m_sel);
        e.grant   = (m_owner < 0) ? 16'd0 : (16'd1 << m_owner);
        e.valid   = (m_owner >= 0);
        e.timeout = m_to;
        exp_q.push_back(e);
    endtask

    task automatic apply(input logic [15:0] r, input logic d, input logic rs);
        req = r; done = d; reset = rs;
        model_edge();
    endtask

    task automatic step(input logic [15:0] r, input logic d, input logic rs);
        @(posedge clk);
        #1;
        apply(r, d, rs);
    endtask

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, want);
        end
    endtask

    // Monitor: outputs are stable well after the edge and before the next
    // stimulus update lands.
    initial begin
        forever begin
            @(posedge clk);
            #3;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("sel", {12'd0, sel}, {12'd0, e.sel});
                check("grant", grant, e.grant);
                check("valid", {15'd0, valid}, {15'd0, e.valid});
                check("timeout", {15'd0, timeout}, {15'd0, e.timeout});
            end
        end
    end

    initial begin
        logic [15:0] r;
        apply(16'h0000, 1'b0, 1'b1);
        // Idle with no requests.
        for (int i = 0; i < 10; i++) step(16'h0000, 1'b0, 1'b0);
        // Two requesters at opposite ends, done every cycle.
        for (int i = 0; i < 10; i++) step(16'h8001, 1'b1, 1'b0);
        step(16'h0000, 1'b0, 1'b1);
        // Full sweep.
        for (int i = 0; i < 36; i++) step(16'hFFFF, 1'b1, 1'b0);
        step(16'h0000, 1'b0, 1'b1);
        // Requester 5 withdraws, pending 3 follows.
        step(16'h0020, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(16'h0028, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(16'h0008, 1'b0, 1'b0);
        step(16'h0000, 1'b0, 1'b1);
        // Reset in the middle of a grant to 9.
        for (int i = 0; i < 3; i++) step(16'h0200, 1'b0, 1'b0);
        step(16'h0200, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(16'h0200, 1'b0, 1'b0);
        step(16'h0000, 1'b0, 1'b1);
        // Long holds (revoked only when the timeout feature is built).
        for (int i = 0; i < 16; i++) step(16'h0006, 1'b0, 1'b0);
        // done in idle must be ignored.
        step(16'h0000, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(16'h0000, 1'b1, 1'b0);
        // Random traffic: requests change slowly, done and reset are occasional.
        r = 16'h0000;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) r = 16'($urandom) & 16'($urandom);
            step(r, ($urandom_range(0, 3) == 0), ($urandom_range(0, 99) == 0));
        end
        repeat (3) @(posedge clk);
        #4;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mux16_rr_arbiter.md
# mux16_rr_arbiter

Round-robin arbiter that shares the 16:1 single-bit mux (`muxer16`) between 16 requesters. It picks one requester, drives the mux `sel[3:0]` with that requester's index, and holds it until the requester signals completion or withdraws its request. It sits directly upstream of the `muxer16` select input, so `in[k]` reaches `q` only while requester k holds the grant.

## Interface
- `HOLD_MAX`, default 8: maximum number of grant cycles before a forced release. Used only when `MUX16_ARB_TIMEOUT_EN` is defined. Legal range 2..255.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high reset.
- `req` input 16: request vector; bit k belongs to requester k. A requester holds its bit high until it is granted and done.
- `done` input 1: the current owner has finished. Sampled only in state GRANT.
- `sel` output 4: mux select, connected to `muxer16.sel`. Equals the index of the current or most recent grantee.
- `grant` output 16: one-hot grant vector; all zeros when no grant is active.
- `valid` output 1: high while a grant is active; equals `|grant`.
- `timeout` output 1: one-cycle pulse when a grant is forcibly revoked. Tied to 0 when the timeout feature is compiled out.

## Operation
- State machine, 2-bit encoding, two states:
  - IDLE: no owner.
  - GRANT: one owner.
- Round-robin pointer `ptr[3:0]` names the highest-priority index for the next arbitration.
  - Priority order is `ptr`, `ptr+1`, … , 15, 0, … , `ptr-1` (mod 16).
- IDLE behaviour:
  - If `req != 0`, select the first set bit `g` in priority order.
  - At the next edge: `sel <= g`, `grant <= 1<<g`, `valid <= 1`, `ptr <= g+1` (4-bit wrap, so 15→0), state → GRANT.
  - If `req == 0`, stay in IDLE; `sel` keeps its last value.
- GRANT behaviour:
  - Release condition: `done == 1` or `req[sel] == 0`.
  - On release: at the next edge `grant <= 0`, `valid <= 0`, state → IDLE. `sel` is unchanged.
  - Otherwise, hold every output unchanged.
  - `req` changes on other bits have no effect while in GRANT (no preemption).
- Boundary cases:
  - Only one requester active: it is re-granted after every IDLE gap; `ptr` wraps past it harmlessly.
  - `done` and a drop of `req[sel]` in the same cycle count as a single release.
  - `done` asserted in IDLE is ignored.
  - Reset asserted mid-grant clears everything at that edge; the grant is lost and the requester must re-arbitrate.

## Timing
- Reset values: state IDLE, `ptr`=0, `sel`=0, `grant`=0, `valid`=0, `timeout`=0, hold counter=0.
- All outputs are registered; there is no combinational path from `req` or `done` to any output.
- Request-to-grant latency: 1 cycle. `req` seen high at edge n in IDLE gives `grant` high after edge n.
- Release-to-next-grant: the release edge returns the block to IDLE; the earliest next grant is one edge later. This gives a mandatory 1-cycle gap with `valid` low between owners.
- Minimum grant length: 1 cycle, i.e. `done` high in the first GRANT cycle.
- Throughput for continuous requesters: one grant every 2 + (hold cycles − 1) cycles.

## Configuration
- Macro: `MUX16_ARB_TIMEOUT_EN`.
- Defined:
  - An 8-bit hold counter clears on entry to GRANT and increments each GRANT cycle.
  - If no release occurs and the counter reaches `HOLD_MAX`-1, the next edge forces a release: state → IDLE, `grant` → 0, `timeout` = 1 for exactly one cycle.
  - `ptr` already points past the offender, so another requester wins next if one is pending.
  - A normal release on the same cycle as the limit takes precedence; no `timeout` pulse is generated.
- Undefined:
  - No counter is built and `timeout` is constant 0.
  - A grant is held indefinitely until `done` or request withdrawal.

## Test plan
- Reset then `req`=16'h0000 for 10 cycles → `valid`=0, `grant`=0, `sel`=0 throughout.
- `req`=16'h8001 held, `done` pulsed in every GRANT cycle → grants alternate: `sel`=0, then 15, then 0, …; `ptr` wraps 1→0; there is 1 IDLE cycle between grants.
- `req`=16'hFFFF, `done` pulsed each grant → `sel` sequence 0,1,2,…,15,0 with one-hot `grant` matching; no index is skipped or repeated.
- Requester 5 granted, then `req[5]` dropped without `done` → `grant` clears at the next edge; a pending `req[3]` is granted one cycle later (`sel`=3).
- Reset asserted during a grant of index 9 → after that edge all outputs are 0 and `ptr`=0; with `req`=16'h0200 still high, index 9 is re-granted one edge after reset deasserts.
- `MUX16_ARB_TIMEOUT_EN` defined, `HOLD_MAX`=4, `req`=16'h0006, `done`=0 → index 1 is held for 4 cycles, then `timeout` pulses once; index 2 is granted after the 1-cycle gap and times out 4 cycles later in the same way.
